// File: rtl/exec_controller.sv
// Run/step sequencer for the single-cycle datapath: streams a program into
// instruction memory, then gates PC advance and register-file writes.
module exec_controller #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              start,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic [31:0]       inscode,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              pc_clr,
    output logic              pc_en,
    output logic              regfile_we,
    output logic              busy,
    output logic              done,
    output logic              load_err,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_PAUSED = 3'd3;
    localparam logic [2:0] S_STEP   = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              first_q, first_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic halt_op;
    logic idle_like;
    logic ready;
    logic beat;
    logic pc_clr_c;
    logic pc_en_c;

    assign halt_op   = (inscode[31:26] == 6'b111111);
    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALTED);
    // Qualified by reset so that every output reads 0 while reset is held.
    assign ready     = reset && (idle_like || (state_q == S_LOAD));
    assign beat      = load_valid && ready;

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        first_d   = first_q;
        retired_d = retired_q;
        pc_clr_c  = 1'b0;
        pc_en_c   = 1'b0;

        case (state_q)
            S_IDLE, S_HALTED: begin
                if (beat) begin
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = load_data;
                    err_d   = 1'b0;
                    wptr_d  = ADDR_W'(1);
                    state_d = load_last ? S_IDLE : S_LOAD;
                end else if (start) begin
                    state_d   = S_RUN;
                    first_d   = 1'b1;
                    retired_d = '0;
                end
            end
            S_LOAD: begin
                if (beat) begin
                    we_d    = 1'b1;
                    waddr_d = wptr_q;
                    wdata_d = load_data;
                    if (load_last) begin
                        state_d = S_IDLE;
                    end else if (wptr_q == ADDR_MAX) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        wptr_d = wptr_q + ADDR_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (first_q) begin
                    pc_clr_c = 1'b1;
                    first_d  = 1'b0;
                    if (halt_req) state_d = S_PAUSED;
                end else begin
                    pc_en_c = !halt_op;
                    if (halt_op)       state_d = S_HALTED;
                    else if (halt_req) state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (step_req)   state_d = S_STEP;
                else if (start) state_d = S_RUN;
            end
            S_STEP: begin
                pc_en_c = !halt_op;
                state_d = halt_op ? S_HALTED : S_PAUSED;
            end
            default: state_d = S_IDLE;
        endcase

        if (pc_en_c && (retired_q != CNT_MAX)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            first_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            first_q   <= first_d;
            retired_q <= retired_d;
        end
    end

    assign load_ready = ready;
    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign pc_clr     = pc_clr_c;
    assign pc_en      = pc_en_c;
    assign regfile_we = pc_en_c;
    assign busy       = (state_q == S_LOAD) || (state_q == S_RUN) ||
                        (state_q == S_PAUSED) || (state_q == S_STEP);
    assign done       = (state_q == S_HALTED);
    assign load_err   = err_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_exec_controller.sv
// Scoreboard bench for exec_controller: emulates the fetch unit and imem, and
// predicts write and execute traces from a program-level model.
module tb_exec_controller;

    localparam int ADDR_W   = 8;
    localparam int S_ADDR_W = 2;
    localparam int CNT_W    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              load_valid, load_last, load_ready;
    logic [31:0]       load_data;
    logic              start, halt_req, step_req;
    logic [31:0]       inscode;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              pc_clr, pc_en, regfile_we, busy, done, load_err;
    logic [CNT_W-1:0]  retired;

    logic                s_load_valid, s_load_last, s_load_ready;
    logic [31:0]         s_load_data;
    logic                s_imem_we;
    logic [S_ADDR_W-1:0] s_imem_waddr;
    logic [31:0]         s_imem_wdata;
    logic                s_pc_clr, s_pc_en, s_regfile_we, s_busy, s_done, s_load_err;
    logic [CNT_W-1:0]    s_retired;

    exec_controller #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .start(start), .halt_req(halt_req),
        .step_req(step_req), .inscode(inscode), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .pc_clr(pc_clr),
        .pc_en(pc_en), .regfile_we(regfile_we), .busy(busy), .done(done),
        .load_err(load_err), .retired(retired)
    );

    // Tiny-memory instance used only to exercise the write-pointer limit.
    exec_controller #(.ADDR_W(S_ADDR_W), .CNT_W(CNT_W)) dut_small (
        .clk(clk), .reset(reset),
        .load_valid(s_load_valid), .load_data(s_load_data), .load_last(s_load_last),
        .load_ready(s_load_ready), .start(1'b0), .halt_req(1'b0),
        .step_req(1'b0), .inscode(32'h0), .imem_we(s_imem_we),
        .imem_waddr(s_imem_waddr), .imem_wdata(s_imem_wdata), .pc_clr(s_pc_clr),
        .pc_en(s_pc_en), .regfile_we(s_regfile_we), .busy(s_busy), .done(s_done),
        .load_err(s_load_err), .retired(s_retired)
    );

    int vectors     = 0;
    int miscompares = 0;
    int clr_count   = 0;

    logic [39:0] wq[$];
    logic [39:0] swq[$];
    int          pcq[$];
    logic [31:0] prog[0:31];

    logic [31:0] imem[0:255];
    logic [7:0]  pc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else begin
            if (imem_we) imem[imem_waddr] <= imem_wdata;
            if (pc_clr)     pc <= '0;
            else if (pc_en) pc <= pc + 8'd1;
        end
    end

    always_comb inscode = imem[pc];

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic report_unexpected(input string name, input logic [63:0] actual);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got event at %0h, expected no event", name, actual);
    endtask

    always @(negedge clk) begin : monitor
        logic [39:0] e;
        int          p;
        if (reset) begin
            if (imem_we) begin
                if (wq.size() == 0) begin
                    report_unexpected("imem write", 64'(imem_waddr));
                end else begin
                    e = wq.pop_front();
                    check_output("imem waddr", 64'(imem_waddr), 64'(e[39:32]));
                    check_output("imem wdata", 64'(imem_wdata), 64'(e[31:0]));
                end
            end
            if (s_imem_we) begin
                if (swq.size() == 0) begin
                    report_unexpected("small imem write", 64'(s_imem_waddr));
                end else begin
                    e = swq.pop_front();
                    check_output("small imem waddr", 64'(s_imem_waddr), 64'(e[39:32]));
                    check_output("small imem wdata", 64'(s_imem_wdata), 64'(e[31:0]));
                end
            end
            if (pc_clr) begin
                clr_count++;
                check_output("pc_en during pc_clr", 64'(pc_en), 64'(0));
            end
            if (pc_en || regfile_we) begin
                if (pcq.size() == 0) begin
                    report_unexpected("execute", 64'(pc));
                end else begin
                    p = pcq.pop_front();
                    check_output("execute pc", 64'(pc), 64'(p));
                    check_output("pc_en", 64'(pc_en), 64'(1));
                    check_output("regfile_we", 64'(regfile_we), 64'(1));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build_prog(input int n_exec);
        logic [31:0] w;
        for (int i = 0; i < n_exec; i++) begin
            w = $urandom;
            if (w[31:26] == 6'b111111) w[31] = 1'b0;
            prog[i] = w;
        end
        w = $urandom;
        prog[n_exec] = {6'b111111, w[25:0]};
    endtask

    task automatic apply_stimulus_load(input int n, input bit with_start);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = (i == n - 1);
            start      = with_start && (i == 0);
            wq.push_back({8'(i), prog[i]});
            tick();
            check_output("write one cycle after beat", 64'(imem_we), 64'(1));
            if (with_start && i == 0 && n > 1) begin
                check_output("start+beat enters load", 64'({busy, done}), 64'(2'b10));
            end
            start = 1'b0;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        tick();
        check_output("no write without beat", 64'(imem_we), 64'(0));
        tick();
        check_output("writes drained", 64'(wq.size()), 64'(0));
        check_output("idle after load", 64'({busy, done, load_err}), 64'(0));
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (!done && c < budget) begin
            tick();
            c++;
        end
        check_output("halted within budget", 64'(done), 64'(1));
    endtask

    // k = 0: plain run; 1..len: halt_req in execute cycle k; len+1: with HALT.
    task automatic run_scenario(input int len, input int k, input int steps,
                                input bit with_start);
        int  clr0;
        int  p;
        bit  halted;
        build_prog(len);
        apply_stimulus_load(len + 1, with_start);
        clr0 = clr_count;
        for (int i = 0; i < ((k == 0 || k > len) ? len : k); i++) pcq.push_back(i);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (k == 0) begin
            wait_done(64);
        end else begin
            repeat (k) tick();
            halt_req = 1'b1;
            tick();
            halt_req = 1'b0;
            tick();
            if (k > len) begin
                check_output("halt wins over halt_req", 64'({busy, done}), 64'(2'b01));
            end else begin
                check_output("paused", 64'({busy, done}), 64'(2'b10));
                check_output("retired at pause", 64'(retired), 64'(k));
                p = k;
                halted = 1'b0;
                for (int s = 0; s < steps; s++) begin
                    if (!halted) begin
                        if (p < len) begin
                            pcq.push_back(p);
                            p++;
                        end else begin
                            halted = 1'b1;
                        end
                    end
                    step_req = 1'b1;
                    tick();
                    step_req = 1'b0;
                    tick();
                    tick();
                    check_output("retired after step", 64'(retired), 64'(p));
                    check_output("done after step", 64'(done), 64'(halted));
                end
                if (!halted) begin
                    for (int i = p; i < len; i++) pcq.push_back(i);
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    wait_done(64);
                end
            end
        end
        tick();
        check_output("retired at halt", 64'(retired), 64'(len));
        check_output("done at halt", 64'({busy, done}), 64'(2'b01));
        check_output("pc_clr pulses per run", 64'(clr_count - clr0), 64'(1));
        check_output("executes drained", 64'(pcq.size()), 64'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        check_output(name, {load_ready, imem_we, imem_waddr, imem_wdata, pc_clr,
                            pc_en, regfile_we, busy, done, load_err, retired}, 64'(0));
        check_output({"small ", name}, 64'({s_load_ready, s_imem_we, s_imem_waddr,
                     s_pc_clr, s_pc_en, s_regfile_we, s_busy, s_done, s_load_err,
                     s_retired}), 64'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] w;
        reset = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        start = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        s_load_valid = 1'b0; s_load_data = '0; s_load_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("outputs in reset");
        reset = 1'b1;
        tick();
        check_output("idle after reset", 64'({load_ready, busy, done}), 64'(3'b100));

        $display("[TB] tiny memory overflow");
        for (int i = 0; i < 5; i++) begin
            w = $urandom;
            s_load_valid = 1'b1;
            s_load_data  = w;
            s_load_last  = 1'b0;
            swq.push_back({8'(i % 4), w});
            tick();
            if (i == 3) begin
                check_output("overflow sets load_err", 64'(s_load_err), 64'(1));
                check_output("overflow returns idle", 64'({s_busy, s_load_ready}), 64'(2'b01));
            end
            if (i == 4) begin
                check_output("next load clears load_err", 64'({s_busy, s_load_err}), 64'(2'b10));
            end
        end
        s_load_valid = 1'b0;
        tick();
        tick();
        check_output("small writes drained", 64'(swq.size()), 64'(0));

        $display("[TB] three-word load");
        build_prog(2);
        apply_stimulus_load(3, 1'b0);

        $display("[TB] directed run, pause/step, halt collision");
        run_scenario(4, 0, 0, 1'b0);
        run_scenario(8, 2, 3, 1'b0);
        run_scenario(5, 6, 0, 1'b1);

        $display("[TB] randomized runs");
        for (int r = 0; r < 10; r++) begin
            int len;
            int k;
            len = int'($urandom_range(3, 12));
            k   = int'($urandom_range(0, len + 1));
            run_scenario(len, k, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during run");
        build_prog(12);
        apply_stimulus_load(13, 1'b0);
        for (int i = 0; i < 12; i++) pcq.push_back(i);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check_reset_outputs("outputs on reset in run");
        wq.delete();
        pcq.delete();
        tick();
        reset = 1'b1;
        tick();
        check_output("idle after run reset", 64'({load_ready, busy, done, retired}), 64'({3'b100, 16'd0}));

        $display("[TB] reset during load");
        build_prog(10);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = 1'b0;
            wq.push_back({8'(i), prog[i]});
            tick();
        end
        reset = 1'b0;
        #1;
        check_reset_outputs("outputs on reset in load");
        wq.delete();
        load_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_output("idle after load reset", 64'({load_ready, busy, done, load_err}), 64'(4'b1000));
        tick();
        check_output("no write after load reset", 64'(imem_we), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
